// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control slice.
// Holds the FSM state encoding, the opcode/funct values this controller
// understands, ALU operation codes and the datapath mux select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct decoder.
// Ports:
//   funct       - IR[5:0]
//   alu_control - ALU operation for the decoded funct (ADD for unknown codes)
//   rtype_valid - 1 when funct is one of the supported R-type operations
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       rtype_valid
);

  always_comb begin
    alu_control = ALU_ADD;
    rtype_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: rtype_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for a multicycle MIPS datapath.
// The datapath owns PC, memory, IR, register file and ALU; this block only
// holds the sequencing state and drives every select/enable each cycle.
// Ports:
//   clk, reset (async, active-low)
//   opcode, funct    - fields of the current IR
//   zero             - ALU zero flag (BEQ decision)
//   mem_ready        - memory access completes this cycle
//   pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//   reg_write, alu_src_a, alu_src_b, alu_control, pc_src - datapath controls
//   illegal_op       - one-cycle pulse in DECODE for unsupported instructions
//   state            - current state encoding (debug)
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int STATE_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  iord,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            pc_src,
  output logic                  illegal_op,
  output logic [STATE_W-1:0]    state
);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] alu_ctl;
  logic [2:0] rtype_alu_ctl;
  logic       rtype_valid;

  mips_alu_decoder u_alu_dec (
    .funct       (funct),
    .alu_control (rtype_alu_ctl),
    .rtype_valid (rtype_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Outputs are decoded from the state register and the live handshake
  // inputs, so an asynchronous reset silences every control in the same
  // cycle and a stalled access never raises pc_en/ir_write.
  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_ctl    = ALU_AND;
    pc_src     = PCSRC_ALU;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_ctl   = ALU_ADD;
        pc_src    = PCSRC_ALU;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        // Branch target is precomputed into ALUOut while decoding.
        alu_src_b = SRCB_IMM_SH2;
        alu_ctl   = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (rtype_valid) begin
              state_d = S_EXECUTE;
            end else begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctl   = ALU_ADD;
        state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end

      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_B;
        alu_ctl   = rtype_alu_ctl;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_B;
        alu_ctl   = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = zero;
        state_d   = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctl   = ALU_ADD;
        state_d   = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end

      // IDLE and the unused encodings 13-15: all controls low, start fetching.
      default: state_d = S_FETCH;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(alu_ctl);
  assign state       = STATE_W'(state_q);

endmodule
